// File: rtl/txt_pkg.sv
// Shared constants and slot-owner encoding for the text display memory path.
package txt_pkg;

    localparam int         COLS      = 40;
    localparam int         ROWS      = 30;
    localparam int         CELLS     = COLS * ROWS;
    localparam int         ADDR_W    = 12;
    localparam int         DATA_W    = 8;
    localparam logic [7:0] FILL_CHAR = 8'h20;

    typedef enum logic [2:0] {
        SLOT_NONE,
        SLOT_VID,
        SLOT_CPU_RD,
        SLOT_CPU_WR,
        SLOT_CLR
    } slot_t;

    function automatic logic slot_is_write(slot_t s);
        return (s == SLOT_CPU_WR) || (s == SLOT_CLR);
    endfunction

endpackage

// File: rtl/txt_wr_fifo.sv
// Synchronous FIFO of {addr,data} CPU writes; head entry is presented combinationally.
module txt_wr_fifo #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W+DATA_W-1:0] r_mem [DEPTH];
    logic [PW:0]              r_wptr;
    logic [PW:0]              r_rptr;
    logic                     w_do_push;
    logic                     w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (PW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PW-1:0]] <= {i_addr, i_data};
    end

    assign o_empty          = (r_wptr == r_rptr);
    assign o_full           = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign {o_addr, o_data} = r_mem[r_rptr[PW-1:0]];

endmodule

// File: rtl/txt_vram_arbiter.sv
// Text VRAM arbiter: shares the single-port character RAM between renderer fetches,
// buffered CPU writes, blocking CPU reads and a clear-screen fill engine.
module txt_vram_arbiter #(
    parameter int                ADDR_W     = txt_pkg::ADDR_W,
    parameter int                DATA_W     = txt_pkg::DATA_W,
    parameter int                FIFO_DEPTH = 4,
    parameter int                CELLS      = txt_pkg::CELLS,
    parameter logic [DATA_W-1:0] FILL_CHAR  = DATA_W'(txt_pkg::FILL_CHAR)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    input  logic              cpu_re,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import txt_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    slot_t             w_slot;
    slot_t             r_own_p0;
    slot_t             r_own_p1;
    logic              r_rd_inflight;
    logic              r_clr_busy;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_rd_ok;
    logic              w_cpu_ready;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    assign w_cpu_ready = !w_full && !r_clr_busy;
    assign w_push      = cpu_we && w_cpu_ready;
    // Reads wait for buffered writes and the fill so they never observe stale data.
    assign w_rd_ok     = cpu_re && w_empty && !r_clr_busy && !r_rd_inflight;

    always_comb begin
        w_slot = SLOT_NONE;
        if (vid_req)
            w_slot = SLOT_VID;
        else if (w_rd_ok)
            w_slot = SLOT_CPU_RD;
        else if (!w_empty)
            w_slot = SLOT_CPU_WR;
        else if (r_clr_busy)
            w_slot = SLOT_CLR;
    end

    assign w_pop = (w_slot == SLOT_CPU_WR);

    txt_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .clr     (clr),
        .i_push  (w_push),
        .i_addr  (cpu_addr),
        .i_data  (cpu_wdata),
        .i_pop   (w_pop),
        .o_addr  (w_head_addr),
        .o_data  (w_head_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Issue stage: winner of cycle N drives the RAM port in N+1
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_own_p0    <= SLOT_NONE;
        end else begin
            r_own_p0 <= w_slot;
            r_mem_en <= (w_slot != SLOT_NONE);
            r_mem_we <= slot_is_write(w_slot);
            case (w_slot)
                SLOT_VID:    r_mem_addr <= vid_addr;
                SLOT_CPU_RD: r_mem_addr <= cpu_addr;
                SLOT_CPU_WR: begin
                    r_mem_addr  <= w_head_addr;
                    r_mem_wdata <= w_head_data;
                end
                SLOT_CLR: begin
                    r_mem_addr  <= r_clr_addr;
                    r_mem_wdata <= FILL_CHAR;
                end
                default: ;
            endcase
        end
    end

    // Data-return stage: RAM read data is valid while the owner sits here
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_own_p1      <= SLOT_NONE;
            r_rd_inflight <= 1'b0;
        end else begin
            r_own_p1 <= r_own_p0;
            if (w_slot == SLOT_CPU_RD)
                r_rd_inflight <= 1'b1;
            else if (r_own_p1 == SLOT_CPU_RD)
                r_rd_inflight <= 1'b0;
        end
    end

    // A restart request outranks the increment of a fill write issued the same cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_clr_busy <= 1'b0;
            r_clr_addr <= '0;
        end else if (clear_start) begin
            r_clr_busy <= 1'b1;
            r_clr_addr <= '0;
        end else if (w_slot == SLOT_CLR) begin
            if (r_clr_addr == LAST_CELL) begin
                r_clr_busy <= 1'b0;
                r_clr_addr <= '0;
            end else begin
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end
        end
    end

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign vid_data   = mem_rdata;
    assign cpu_rdata  = mem_rdata;
    assign vid_valid  = (r_own_p1 == SLOT_VID);
    assign cpu_rvalid = (r_own_p1 == SLOT_CPU_RD);
    assign cpu_ready  = w_cpu_ready;
    assign clear_busy = r_clr_busy;

endmodule
